// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue
// Instruction-fetch front end for the 5-stage MIPS pipe. In-order requests
// go to a variable-latency instruction memory. Responses are buffered in a
// DEPTH-entry prefetch FIFO that feeds the IF/ID register. Decode can hold
// the IF/ID register (stall). A branch/jump redirect flushes the front end
// and refetches from the target.
//
// Credit scheme: a new request is issued only while the buffered entries
// plus the outstanding requests stay below DEPTH. Every response therefore
// has a FIFO slot reserved for it. Responses that a redirect turns stale
// keep their credit until they return and are discarded.

module mips_fetch_queue #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           INSTR_WIDTH = 32,
   parameter int unsigned           DEPTH       = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}},
   parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4)
) (
   input  logic                   clk_87,
   input  logic                   rst_87,
   output logic                   imem_req_87,
   output logic [ADDR_WIDTH-1:0]  imem_addr_87,
   input  logic                   imem_gnt_87,
   input  logic                   imem_rvalid_87,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_87,
   input  logic                   stall_87,
   input  logic                   redirect_87,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc_87,
   output logic [INSTR_WIDTH-1:0] instr_id_87,
   output logic [ADDR_WIDTH-1:0]  pc_id_87,
   output logic                   valid_id_87
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // Fetch/response program counters
   logic [ADDR_WIDTH-1:0]  r_fetch_pc;
   logic [ADDR_WIDTH-1:0]  r_resp_pc;

   // Occupancy, outstanding requests, and stale responses still to discard
   logic [CW-1:0]          r_count;
   logic [CW-1:0]          r_infl;
   logic [CW-1:0]          r_drop;

   // Prefetch FIFO storage and circular pointers
   logic [INSTR_WIDTH-1:0] r_fifo_instr [DEPTH];
   logic [ADDR_WIDTH-1:0]  r_fifo_pc    [DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;

   // IF/ID register
   logic [INSTR_WIDTH-1:0] r_instr_id;
   logic [ADDR_WIDTH-1:0]  r_pc_id;
   logic                   r_valid_id;

   // Combinational control
   logic [CW:0]            w_occ;
   logic                   w_credit_ok;
   logic                   w_req;
   logic                   w_fire;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_discard;
   logic [CW-1:0]          w_infl_next;
   logic [CW-1:0]          w_drop_next;
   logic [CW-1:0]          w_count_next;
   logic [PW-1:0]          w_wr_ptr_next;
   logic [PW-1:0]          w_rd_ptr_next;

   // Circular pointer advance; DEPTH need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == LAST_PTR) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   // Request issue, response acceptance and FIFO pop decisions
   always_comb begin
      w_occ       = {1'b0, r_count} + {1'b0, r_infl};
      w_credit_ok = (w_occ < DEPTH_W);
      w_req       = rst_87 & ~redirect_87 & w_credit_ok;
      w_fire      = w_req & imem_gnt_87;
      // A response is consumed either as a stale drop or as a FIFO push
      w_discard   = imem_rvalid_87 & ((r_drop != {CW{1'b0}}) | redirect_87);
      w_push      = rst_87 & imem_rvalid_87 & ~redirect_87 & (r_drop == {CW{1'b0}});
      w_pop       = ~redirect_87 & ~stall_87 & (r_count != {CW{1'b0}});
   end

   // Next-state values of the credit counters and FIFO pointers
   always_comb begin
      w_infl_next   = r_infl + CW'(w_fire) - CW'(imem_rvalid_87);
      w_drop_next   = r_drop;
      w_count_next  = r_count;
      w_wr_ptr_next = r_wr_ptr;
      w_rd_ptr_next = r_rd_ptr;
      if (redirect_87) begin
         // All outstanding responses, including one returning now, go stale
         w_drop_next   = w_infl_next;
         w_count_next  = {CW{1'b0}};
         w_wr_ptr_next = {PW{1'b0}};
         w_rd_ptr_next = {PW{1'b0}};
      end else begin
         if (imem_rvalid_87 && (r_drop != {CW{1'b0}})) begin
            w_drop_next = r_drop - CW'(1);
         end else begin
            w_drop_next = r_drop;
         end
         w_count_next = r_count + CW'(w_push) - CW'(w_pop);
         if (w_push) begin
            w_wr_ptr_next = ptr_inc(r_wr_ptr);
         end else begin
            w_wr_ptr_next = r_wr_ptr;
         end
         if (w_pop) begin
            w_rd_ptr_next = ptr_inc(r_rd_ptr);
         end else begin
            w_rd_ptr_next = r_rd_ptr;
         end
      end
   end

   // Fetch and response PC tracking; PC arithmetic wraps at 2^ADDR_WIDTH
   always_ff @(posedge clk_87) begin
      if (!rst_87) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
      end else if (redirect_87) begin
         r_fetch_pc <= redirect_pc_87;
         r_resp_pc  <= redirect_pc_87;
      end else begin
         if (w_fire) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + PC_STEP;
         end
      end
   end

   // Credit counters and FIFO pointers
   always_ff @(posedge clk_87) begin
      if (!rst_87) begin
         r_count  <= {CW{1'b0}};
         r_infl   <= {CW{1'b0}};
         r_drop   <= {CW{1'b0}};
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
      end else begin
         r_count  <= w_count_next;
         r_infl   <= w_infl_next;
         r_drop   <= w_drop_next;
         r_wr_ptr <= w_wr_ptr_next;
         r_rd_ptr <= w_rd_ptr_next;
      end
   end

   // Write an accepted response with its PC at the FIFO tail
   always_ff @(posedge clk_87) begin
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= imem_rdata_87;
         r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      end
   end

   // IF/ID register: redirect bubbles, stall holds, otherwise pop or bubble
   always_ff @(posedge clk_87) begin
      if (!rst_87) begin
         r_instr_id <= {INSTR_WIDTH{1'b0}};
         r_pc_id    <= {ADDR_WIDTH{1'b0}};
         r_valid_id <= 1'b0;
      end else if (redirect_87) begin
         r_valid_id <= 1'b0;
      end else if (!stall_87) begin
         if (r_count != {CW{1'b0}}) begin
            r_instr_id <= r_fifo_instr[r_rd_ptr];
            r_pc_id    <= r_fifo_pc[r_rd_ptr];
            r_valid_id <= 1'b1;
         end else begin
            r_valid_id <= 1'b0;
         end
      end else begin
         r_valid_id <= r_valid_id;
      end
   end

   assign imem_req_87  = w_req;
   assign imem_addr_87 = r_fetch_pc;
   assign instr_id_87  = r_instr_id;
   assign pc_id_87     = r_pc_id;
   assign valid_id_87  = r_valid_id;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue.
// The instruction memory returns mem[a] = a | 0xA000 after a programmable
// latency. The expected behaviour comes from a transaction-level model:
// outstanding requests carry a stale tag, and decode-ready entries sit in a
// queue. A negedge process compares every DUT output against that model on
// every cycle. Directed literal checks pin the model at the key scenarios.

module tb_mips_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk_87 = 1'b0;
   logic        rst_87;
   logic        imem_req_87;
   logic [31:0] imem_addr_87;
   logic        imem_gnt_87;
   logic        imem_rvalid_87;
   logic [31:0] imem_rdata_87;
   logic        stall_87;
   logic        redirect_87;
   logic [31:0] redirect_pc_87;
   logic [31:0] instr_id_87;
   logic [31:0] pc_id_87;
   logic        valid_id_87;

   mips_fetch_queue #(
      .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH),
      .RESET_PC(32'h0), .PC_STEP(32'h4)
   ) dut (
      .clk_87(clk_87), .rst_87(rst_87),
      .imem_req_87(imem_req_87), .imem_addr_87(imem_addr_87), .imem_gnt_87(imem_gnt_87),
      .imem_rvalid_87(imem_rvalid_87), .imem_rdata_87(imem_rdata_87),
      .stall_87(stall_87), .redirect_87(redirect_87), .redirect_pc_87(redirect_pc_87),
      .instr_id_87(instr_id_87), .pc_id_87(pc_id_87), .valid_id_87(valid_id_87)
   );

   always #5 clk_87 = ~clk_87;

   typedef struct packed { logic [31:0] addr; logic stale; } out_t;
   typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
   typedef struct packed { logic [31:0] addr; int ready; } mreq_t;

   // Model state
   out_t        m_out[$];
   ent_t        m_fq[$];
   logic [31:0] m_next_addr;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_valid;

   // Memory stimulus state
   mreq_t       mq[$];
   int          lat;
   int          cyc;
   bit          rand_gnt;

   int          checks;
   int          errors;
   bit          chk_en;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a | 32'h0000_A000;
   endfunction

   function automatic logic exp_req();
      return rst_87 && !redirect_87 && ((m_fq.size() + m_out.size()) < DEPTH);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: sample pre-edge inputs, advance model and memory
   task automatic tick();
      logic s_rst, s_redir, s_stall, s_rv, m_fire, d_fire;
      logic [31:0] s_rpc, d_addr;
      out_t o;
      ent_t e;
      mreq_t mr;
      @(negedge clk_87);
      s_rst   = rst_87;
      s_redir = redirect_87;
      s_stall = stall_87;
      s_rpc   = redirect_pc_87;
      s_rv    = imem_rvalid_87;
      m_fire  = exp_req() && imem_gnt_87;
      d_fire  = imem_req_87 && imem_gnt_87;
      d_addr  = imem_addr_87;
      @(posedge clk_87);
      #1;
      cyc++;
      if (!s_rst) begin
         m_out.delete();
         m_fq.delete();
         mq.delete();
         m_next_addr = 32'h0;
         m_instr     = 32'h0;
         m_pc        = 32'h0;
         m_valid     = 1'b0;
      end else begin
         if (s_redir) begin
            m_valid = 1'b0;
            m_fq.delete();
         end else if (!s_stall) begin
            if (m_fq.size() != 0) begin
               e = m_fq.pop_front();
               m_instr = e.instr;
               m_pc    = e.pc;
               m_valid = 1'b1;
            end else begin
               m_valid = 1'b0;
            end
         end
         if (s_rv) begin
            chk("rvalid_credit", 64'(m_out.size() != 0), 64'd1);
            if (m_out.size() != 0) begin
               o = m_out.pop_front();
               if (!o.stale && !s_redir) m_fq.push_back({mem_f(o.addr), o.addr});
            end
            chk("fifo_bound", 64'(m_fq.size() <= DEPTH), 64'd1);
         end
         if (m_fire) begin
            m_out.push_back({m_next_addr, 1'b0});
            m_next_addr = m_next_addr + 32'h4;
         end
         if (s_redir) begin
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_next_addr = s_rpc;
         end
         if (d_fire) mq.push_back({d_addr, cyc + lat - 1});
      end
      if (s_rst && mq.size() != 0 && mq[0].ready <= cyc) begin
         mr = mq.pop_front();
         imem_rvalid_87 = 1'b1;
         imem_rdata_87  = mem_f(mr.addr);
      end else begin
         imem_rvalid_87 = 1'b0;
         imem_rdata_87  = 32'h0;
      end
      imem_gnt_87 = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (!valid_id_87 && n < budget) begin
         tick();
         n++;
      end
      chk(name, 64'(valid_id_87), 64'd1);
   endtask

   // Cycle-by-cycle comparison of every DUT output against the model
   always @(negedge clk_87) begin
      if (chk_en) begin
         chk("imem_req", 64'(imem_req_87), 64'(exp_req()));
         if (exp_req()) chk("imem_addr", 64'(imem_addr_87), 64'(m_next_addr));
         chk("valid_id", 64'(valid_id_87), 64'(m_valid));
         chk("instr_id", 64'(instr_id_87), 64'(m_instr));
         chk("pc_id", 64'(pc_id_87), 64'(m_pc));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_87 = 1'b0; imem_gnt_87 = 1'b1; imem_rvalid_87 = 1'b0; imem_rdata_87 = 32'h0;
      stall_87 = 1'b0; redirect_87 = 1'b0; redirect_pc_87 = 32'h0;
      lat = 1; cyc = 0; rand_gnt = 1'b0; checks = 0; errors = 0; chk_en = 1'b0;

      // 1: reset, zero-wait memory, first instructions
      repeat (3) begin
         tick();
         chk_en = 1'b1;
         chk("req_in_reset", 64'(imem_req_87), 64'd0);
         chk("valid_in_reset", 64'(valid_id_87), 64'd0);
      end
      rst_87 = 1'b1; #1;
      chk("first_addr", 64'(imem_addr_87), 64'h0);
      tick(); chk("addr_step", 64'(imem_addr_87), 64'h4);
      chk("valid_e1", 64'(valid_id_87), 64'd0);
      tick(); chk("valid_e2", 64'(valid_id_87), 64'd0);
      tick(); chk("valid_e3", 64'(valid_id_87), 64'd1);
      chk("instr0", 64'(instr_id_87), 64'hA000); chk("pc0", 64'(pc_id_87), 64'h0);
      tick(); chk("instr1", 64'(instr_id_87), 64'hA004); chk("pc1", 64'(pc_id_87), 64'h4);
      tick(); chk("instr2", 64'(instr_id_87), 64'hA008); chk("pc2", 64'(pc_id_87), 64'h8);

      // 2: decode stall fills the queue, then release and random grants
      stall_87 = 1'b1;
      repeat (6) tick();
      chk("req_full", 64'(imem_req_87), 64'd0);
      chk("pc_frozen", 64'(pc_id_87), 64'h8);
      stall_87 = 1'b0;
      tick(); chk("pc_after_stall", 64'(pc_id_87), 64'hC);
      tick(); chk("pc_after_stall2", 64'(pc_id_87), 64'h10);
      rand_gnt = 1'b1;
      repeat (20) tick();
      rand_gnt = 1'b0;
      repeat (4) tick();

      // 3: latency 3, redirect with two requests in flight
      rst_87 = 1'b0; lat = 3;
      repeat (2) tick();
      rst_87 = 1'b1;
      repeat (2) tick();
      redirect_87 = 1'b1; redirect_pc_87 = 32'h100; #1;
      chk("req_in_redirect", 64'(imem_req_87), 64'd0);
      tick(); redirect_87 = 1'b0;
      chk("drop_two", 64'(dut.r_drop), 64'd2);
      wait_valid("t3_wait1", 30);
      chk("t3_pc0", 64'(pc_id_87), 64'h100); chk("t3_instr0", 64'(instr_id_87), 64'hA100);
      tick(); wait_valid("t3_wait2", 30);
      chk("t3_pc1", 64'(pc_id_87), 64'h104);

      // 4: redirect and stall together
      stall_87 = 1'b1; redirect_87 = 1'b1; redirect_pc_87 = 32'h300;
      tick(); stall_87 = 1'b0; redirect_87 = 1'b0;
      chk("t4_valid", 64'(valid_id_87), 64'd0);
      chk("t4_pc_hold", 64'(pc_id_87), 64'h104);
      wait_valid("t4_wait", 30);
      chk("t4_pc", 64'(pc_id_87), 64'h300);

      // 5: latency 2, redirect coincident with a response, one older in flight
      lat = 2;
      repeat (8) tick();
      n = 0;
      while (!(imem_rvalid_87 && m_out.size() == 2) && n < 20) begin
         tick();
         n++;
      end
      chk("t5_setup", 64'(imem_rvalid_87 && m_out.size() == 2), 64'd1);
      redirect_87 = 1'b1; redirect_pc_87 = 32'h200;
      tick(); redirect_87 = 1'b0;
      chk("t5_drop", 64'(dut.r_drop), 64'd1);
      wait_valid("t5_wait1", 30);
      chk("t5_pc0", 64'(pc_id_87), 64'h200);
      tick(); wait_valid("t5_wait2", 30);
      chk("t5_pc1", 64'(pc_id_87), 64'h204);
      chk("t5_drop_zero", 64'(dut.r_drop), 64'd0);

      // 6: address wrap, then reset mid-stream
      lat = 1;
      redirect_87 = 1'b1; redirect_pc_87 = 32'hFFFF_FFFC;
      tick(); redirect_87 = 1'b0; #1;
      chk("t6_addr_top", 64'(imem_addr_87), 64'hFFFF_FFFC);
      tick(); chk("t6_addr_wrap", 64'(imem_addr_87), 64'h0);
      wait_valid("t6_wait1", 30);
      chk("t6_pc_top", 64'(pc_id_87), 64'hFFFF_FFFC);
      tick(); wait_valid("t6_wait2", 30);
      chk("t6_pc_wrap", 64'(pc_id_87), 64'h0);
      tick();
      rst_87 = 1'b0;
      repeat (2) tick();
      chk("t6_rst_valid", 64'(valid_id_87), 64'd0);
      chk("t6_rst_req", 64'(imem_req_87), 64'd0);
      chk("t6_rst_pc", 64'(pc_id_87), 64'h0);
      rst_87 = 1'b1; #1;
      chk("t6_restart_addr", 64'(imem_addr_87), 64'h0);
      chk("t6_restart_req", 64'(imem_req_87), 64'd1);
      repeat (3) tick();
      chk("t6_first_valid", 64'(valid_id_87), 64'd1);
      chk("t6_first_pc", 64'(pc_id_87), 64'h0);
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
